fp_square_iter: RTL and testbench
=================================

Name: fp_square_iter

Overview:
- Iterative IEEE-754 floating-point squarer, z = a*a; the inverse operation of fp_sqrt.
- Shares fp_sqrt's operand format, round_t rounding encoding and 8-bit status layout, so the two are interchangeable in the FP unit datapath.
- Significand product formed by a radix-2 shift-add iteration: small area, fixed latency, start/done handshake.

Parameters:
sig_width, 23, fraction width (hidden bit excluded)
ex_width, 8, exponent width; bias = 2**(ex_width-1)-1

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
enable  in  1  global clock enable; 0 freezes all state and outputs
start  in  1  request; sampled only in IDLE with enable=1
a  in  sig_width+ex_width+1  operand {sign, exp, frac}
round  in  3  rounding mode, round_t encoding
z  out  sig_width+ex_width+1  result, held until next accepted start
status  out  8  [0] zero, [1] inf, [2] invalid/NaN, [3] tiny, [4] huge, [5] inexact, [7:6] 0
busy  out  1  high from the cycle after accepted start until the cycle done rises
done  out  1  one-cycle pulse; z/status valid from this cycle

Behaviour:
- Reset (async, any state): state=IDLE; z, status, busy, done = 0; iteration counter = 0.
- FSM (sq_state_t): IDLE -> MUL -> RND -> FIN -> IDLE. Advances only when enable=1.
- IDLE, start=1: capture a, round; latch special-case class; clear accumulator; counter=0; go to MUL.
- start is ignored in every state other than IDLE (no queueing).
- MUL: one shift-add step per cycle over a (sig_width+1)-bit multiplier. The product accumulates in 2*(sig_width+1) bits.
- MUL runs exactly sig_width+1 cycles, then goes to RND.
- Special operands still pass through MUL, so latency is constant.
- RND:
  - If product MSB is set: shift right 1, exp+1.
  - Keep sig_width+1 bits plus guard; all remaining bits OR into sticky.
  - Round via round_gs with sign=0.
  - A rounding carry-out renormalises: shift right 1, exp+1.
- Exponent: z_exp = 2*a_exp - bias (+ normalisation increments), computed in ex_width+2 signed bits; no wrap.
- FIN: register z and status; done=1 for this cycle; busy=0; next state IDLE.
- A start in IDLE may coincide with the FIN->IDLE cycle, i.e. the cycle after done (back-to-back issue).
- Latency: start sampled at edge 0 -> done high after edge sig_width+3. Total sig_width+3 enabled cycles; enable-low cycles extend it.
- Result sign is always 0.
- Special cases:
  - NaN input -> canonical quiet NaN {0, all-ones exp, 1 followed by zeros}, status[2].
  - Inf -> +Inf, status[1].
  - Zero or subnormal input -> +0, status[0]. Subnormals are flushed, with no inexact.
- Overflow (biased exp >= 2**ex_width-1):
  - Rounding RNE, RNA or RUP -> +Inf, status[1]|[4]|[5].
  - Rounding RTZ or RDN -> max finite, status[4]|[5].
- Underflow (biased exp <= 0) -> +0, status[0]|[3]|[5] (flush-to-zero).
- Inexact: guard|sticky nonzero on a normal result -> status[5].
- Reset mid-operation: abort immediately, return to IDLE, clear outputs. No done is emitted.

Decomposition:
- enum_typedefs_pkg: add sq_state_t {IDLE, MUL, RND, FIN}. round_t is reused unchanged.
- Sub-module sqr_sigiter: holds the multiplicand and multiplier shift registers, the accumulator and the counter. Interface: load, step, product, last.
- Rounding reuses round_gs. Exponent arithmetic and special-case logic stay in the top module.

Test Plan:
- sig_width=23, a=0x40000000 (2.0), RNE, start pulse -> done exactly 26 cycles later; z=0x40800000, status=0x00; busy high for cycles 1..25.
- a=0x3F800001, RNE -> z=0x3F800002, status=0x20. Same operand with RUP -> z=0x3F800003, status=0x20. a=0x3FC00000 -> z=0x40100000, status=0x00.
- a=0x7F000000, RNE -> z=0x7F800000, status=0x32. Same operand with RTZ -> z=0x7F7FFFFF, status=0x30.
- a=0x1F000000 -> z=0x00000000, status=0x29. a=0x80000000 -> z=0x00000000, status=0x01. a=0xFFC00000 -> z=0x7FC00000, status=0x04. a=0xFF800000 -> z=0x7F800000, status=0x02.
- Second start asserted while busy -> ignored, exactly one done. Start in the cycle after done -> accepted, second result correct.
- enable held low for 5 cycles mid-MUL -> done delayed by exactly 5 cycles with an unchanged result. resetn pulsed low mid-MUL -> outputs 0 immediately, no done, next start works normally.

Source files
------------

// File: rtl/fp_square_iter_pkg.sv
// Shared types for the iterative floating-point squarer.
// Holds the rounding-mode encoding (same as fp_sqrt), the FSM and
// operand-class enums, the status bit positions, and the guard/sticky
// rounding-increment helper used by both operators.
package fp_square_iter_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RUP = 3'd2,
    RDN = 3'd3,
    RNA = 3'd4
  } round_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RND,
    FIN
  } sq_state_t;

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } sq_class_t;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_NAN     = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  // Returns 1 when the kept significand must be incremented by one ulp.
  function automatic logic round_gs(input logic   sign,
                                    input logic   lsb,
                                    input logic   guard,
                                    input logic   sticky,
                                    input round_t mode);
    logic inc;
    case (mode)
      RNE:     inc = guard & (sticky | lsb);
      RUP:     inc = ~sign & (guard | sticky);
      RDN:     inc = sign & (guard | sticky);
      RNA:     inc = guard;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fp_square_iter_sigiter.sv
// Radix-2 shift-add significand multiplier for the squarer.
// Ports:
//   clk, resetn  clock, async active-low reset (counter only)
//   load_i       capture operand as multiplicand and multiplier, clear product
//   step_i       perform one shift-add step
//   op_i         significand with hidden bit, sig_width+1 bits
//   product_o    accumulated product, 2*(sig_width+1) bits
//   last_o       high while the counter points at the final step
module sqr_sigiter #(
  parameter int sig_width = 23
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     load_i,
  input  logic                     step_i,
  input  logic [sig_width:0]       op_i,
  output logic [2*sig_width+1:0]   product_o,
  output logic                     last_o
);
  localparam int MW = sig_width + 1;
  localparam int PW = 2 * MW;
  localparam int CW = $clog2(MW + 1);

  logic [PW-1:0] mcand_q, acc_q;
  logic [MW-1:0] mplier_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Datapath registers carry no reset: load always initialises them first.
  always_ff @(posedge clk) begin
    if (load_i) begin
      mcand_q  <= PW'(op_i);
      mplier_q <= op_i;
      acc_q    <= '0;
    end else if (step_i) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)      cnt_d = '0;
    else if (step_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign last_o    = (cnt_q == CW'(sig_width));
  assign product_o = acc_q;

endmodule

// File: rtl/fp_square_iter.sv
// Iterative IEEE-754 squarer, z = a*a, result sign always 0.
// Ports:
//   clk, resetn    clock, async active-low reset
//   enable         global clock enable, 0 freezes everything
//   start          request, accepted only in IDLE
//   a, round       operand {sign,exp,frac} and round_t mode
//   z, status      result and flags, valid from the done cycle, held after
//   busy, done     busy during MUL/RND, one-cycle done pulse
module fp_square_iter
  import fp_square_iter_pkg::*;
#(
  parameter int sig_width = 23,
  parameter int ex_width  = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic                        start,
  input  logic [sig_width+ex_width:0] a,
  input  logic [2:0]                  round,
  output logic [sig_width+ex_width:0] z,
  output logic [7:0]                  status,
  output logic                        busy,
  output logic                        done
);
  localparam int W    = sig_width + ex_width + 1;
  localparam int MW   = sig_width + 1;
  localparam int PW   = 2 * MW;
  localparam int EW   = ex_width + 2;
  localparam int BIAS = 2**(ex_width-1) - 1;
  localparam int EMAX = 2**ex_width - 1;
  localparam logic signed [EW-1:0] EXP_MAX  = EW'(EMAX);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {ex_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}};
  localparam logic [W-1:0] PINF = {1'b0, {ex_width{1'b1}}, {sig_width{1'b0}}};
  localparam logic [W-1:0] MAXF = {1'b0, {(ex_width-1){1'b1}}, 1'b0, {sig_width{1'b1}}};

  sq_state_t           state_q, state_d;
  sq_class_t           cls_q, cls_d;
  round_t              rnd_q;
  logic [ex_width-1:0] exp_q;
  logic [W-1:0]        res_z_q, res_z_d, z_q;
  logic [7:0]          res_st_q, res_st_d, status_q;
  logic                busy_q, busy_d, done_q, done_d;
  logic                load, step, last;
  logic [PW-1:0]       product;
  logic                unused_sign;

  logic [sig_width-1:0]    frac, frac_r;
  logic                    guard, sticky, inc, carry;
  logic signed [EW-1:0]    exp_n, exp_r;

  // Squaring discards the operand sign.
  assign unused_sign = a[W-1];

  // Overflow saturates to +Inf unless the mode rounds toward zero.
  function automatic logic [W-1:0] ovf_value(input round_t mode);
    if (mode == RTZ || mode == RDN) return MAXF;
    return PINF;
  endfunction

  function automatic logic [7:0] ovf_status(input round_t mode);
    logic [7:0] st;
    st = '0;
    st[ST_HUGE]    = 1'b1;
    st[ST_INEXACT] = 1'b1;
    st[ST_INF]     = !(mode == RTZ || mode == RDN);
    return st;
  endfunction

  sqr_sigiter #(.sig_width(sig_width)) u_sigiter (
    .clk       (clk),
    .resetn    (resetn),
    .load_i    (load),
    .step_i    (step),
    .op_i      ({1'b1, a[sig_width-1:0]}),
    .product_o (product),
    .last_o    (last)
  );

  // Operand class is decided at accept time; specials still run the full
  // iteration so latency never depends on the data.
  always_comb begin
    cls_d = CLS_NORM;
    if (a[sig_width +: ex_width] == '1) begin
      if (a[sig_width-1:0] != '0) cls_d = CLS_NAN;
      else                        cls_d = CLS_INF;
    end else if (a[sig_width +: ex_width] == '0) begin
      cls_d = CLS_ZERO;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    busy_d  = (state_q == MUL) || (state_q == RND);
    done_d  = (state_q == FIN);
    if (enable) begin
      case (state_q)
        IDLE: if (start) begin
          load    = 1'b1;
          state_d = MUL;
        end
        MUL: begin
          step = 1'b1;
          if (last) state_d = RND;
        end
        RND:     state_d = FIN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Normalise, round and classify the finished product.
  always_comb begin
    exp_n = EW'(2 * int'(exp_q) - BIAS);
    if (product[PW-1]) begin
      frac   = product[PW-2 -: sig_width];
      guard  = product[PW-2-sig_width];
      sticky = |product[PW-3-sig_width:0];
      exp_n  = exp_n + EXP_ONE;
    end else begin
      frac   = product[PW-3 -: sig_width];
      guard  = product[PW-3-sig_width];
      sticky = |product[PW-4-sig_width:0];
    end
    inc = round_gs(1'b0, frac[0], guard, sticky, rnd_q);
    // A carry out of the fraction means 1.11..1 rounded up to 10.0: the
    // wrapped fraction is already zero, only the exponent moves.
    {carry, frac_r} = {1'b0, frac} + {{sig_width{1'b0}}, inc};
    exp_r = carry ? exp_n + EXP_ONE : exp_n;

    res_z_d  = '0;
    res_st_d = '0;
    case (cls_q)
      CLS_NAN: begin
        res_z_d          = QNAN;
        res_st_d[ST_NAN] = 1'b1;
      end
      CLS_INF: begin
        res_z_d          = PINF;
        res_st_d[ST_INF] = 1'b1;
      end
      CLS_ZERO: res_st_d[ST_ZERO] = 1'b1;
      default: begin
        if (exp_r >= EXP_MAX) begin
          res_z_d  = ovf_value(rnd_q);
          res_st_d = ovf_status(rnd_q);
        end else if (exp_r <= EXP_ZERO) begin
          res_st_d[ST_ZERO]    = 1'b1;
          res_st_d[ST_TINY]    = 1'b1;
          res_st_d[ST_INEXACT] = 1'b1;
        end else begin
          res_z_d              = {1'b0, exp_r[ex_width-1:0], frac_r};
          res_st_d[ST_INEXACT] = guard | sticky;
        end
      end
    endcase
  end

  // Accept stage: operand fields; RND stage: rounded result.
  always_ff @(posedge clk) begin
    if (load) begin
      exp_q <= a[sig_width +: ex_width];
      rnd_q <= round_t'(round);
      cls_q <= cls_d;
    end
    if (enable && state_q == RND) begin
      res_z_q  <= res_z_d;
      res_st_q <= res_st_d;
    end
  end

  // FIN stage: publish result and flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      z_q      <= '0;
      status_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (state_q == FIN) begin
        z_q      <= res_z_q;
        status_q <= res_st_q;
      end
    end
  end

  assign z      = z_q;
  assign status = status_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fp_square_iter.sv
module tb_fp_square_iter;
  import fp_square_iter_pkg::*;

  localparam int SW = 23;
  localparam int EW = 8;
  localparam int W  = SW + EW + 1;

  logic         clk = 1'b0;
  logic         resetn, enable, start;
  logic [W-1:0] a;
  logic [2:0]   round;
  logic [W-1:0] z;
  logic [7:0]   status;
  logic         busy, done;

  int n_total = 0;
  int n_pass  = 0;

  fp_square_iter #(.sig_width(SW), .ex_width(EW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .enable (enable),
    .start  (start),
    .a      (a),
    .round  (round),
    .z      (z),
    .status (status),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] av;
    logic [2:0]  rm;
    logic [31:0] ez;
    logic [7:0]  es;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Exact square computed with integers, rounded by comparing the discarded
  // remainder against one half ulp.
  function automatic logic [39:0] ref_sq(input logic [31:0] av, input logic [2:0] rm);
    int e, ex, sh;
    longint unsigned f, p, q, rem, half;
    logic up;
    e = int'(av[30:23]);
    f = longint'(av[22:0]);
    if (e == 255) return (f != 0) ? {32'h7FC00000, 8'h04} : {32'h7F800000, 8'h02};
    if (e == 0) return {32'h00000000, 8'h01};
    p  = (64'd8388608 + f) * (64'd8388608 + f);
    ex = 2 * e - 127;
    sh = 23;
    if (p >= 64'h0000_8000_0000_0000) begin
      ex++;
      sh = 24;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    case (rm)
      RNE:     up = (rem > half) || (rem == half && q[0]);
      RUP:     up = (rem != 0);
      RNA:     up = (rem >= half);
      default: up = 1'b0;
    endcase
    q = q + longint'(up);
    if (q == 64'd16777216) begin
      q  = q >> 1;
      ex++;
    end
    if (ex >= 255)
      return (rm == RTZ || rm == RDN) ? {32'h7F7FFFFF, 8'h30} : {32'h7F800000, 8'h32};
    if (ex <= 0) return {32'h00000000, 8'h29};
    return {1'b0, 8'(ex), q[22:0], (rem != 0) ? 8'h20 : 8'h00};
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic issue(input logic [31:0] av, input logic [2:0] rm);
    a     = av;
    round = rm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~av;
  endtask

  task automatic wait_done(input int limit, output int cyc, output logic busy_ok);
    cyc     = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic run_op(input string nm, input logic [31:0] av, input logic [2:0] rm,
                        input logic [31:0] ez, input logic [7:0] es);
    int   cyc;
    logic bok;
    issue(av, rm);
    wait_done(60, cyc, bok);
    chk({nm, " latency"}, cyc, 26);
    chk({nm, " busy"}, bok, 1);
    chk({nm, " z"}, z, ez);
    chk({nm, " status"}, status, es);
  endtask

  initial begin
    logic [39:0] rv;
    logic [31:0] av;
    logic [2:0]  rm;
    int          cyc, nd, dc;
    logic        bok;

    resetn = 1'b0;
    enable = 1'b1;
    start  = 1'b0;
    a      = '0;
    round  = '0;

    vecs[0]  = '{32'h40000000, RNE, 32'h40800000, 8'h00};
    vecs[1]  = '{32'h3F800001, RNE, 32'h3F800002, 8'h20};
    vecs[2]  = '{32'h3F800001, RUP, 32'h3F800003, 8'h20};
    vecs[3]  = '{32'h3FC00000, RNE, 32'h40100000, 8'h00};
    vecs[4]  = '{32'h7F000000, RNE, 32'h7F800000, 8'h32};
    vecs[5]  = '{32'h7F000000, RTZ, 32'h7F7FFFFF, 8'h30};
    vecs[6]  = '{32'h7F000000, RUP, 32'h7F800000, 8'h32};
    vecs[7]  = '{32'h7F000000, RDN, 32'h7F7FFFFF, 8'h30};
    vecs[8]  = '{32'h1F000000, RNE, 32'h00000000, 8'h29};
    vecs[9]  = '{32'h80000000, RNE, 32'h00000000, 8'h01};
    vecs[10] = '{32'hFFC00000, RNE, 32'h7FC00000, 8'h04};
    vecs[11] = '{32'hFF800000, RNE, 32'h7F800000, 8'h02};

    repeat (3) @(negedge clk);
    chk("reset outputs", {z, status, busy, done}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].av, vecs[i].rm, vecs[i].ez, vecs[i].es);

    for (int k = 0; k < 40; k++) begin
      av = $urandom;
      if (k % 2 == 0) av[30:23] = 8'($urandom_range(40, 215));
      rm = 3'($urandom_range(0, 4));
      rv = ref_sq(av, rm);
      run_op($sformatf("rand%0d a=%h rm=%0d", k, av, rm), av, rm, rv[39:8], rv[7:0]);
    end

    // A second start while busy must be ignored.
    issue(32'h3FC00000, RNE);
    nd = 0;
    dc = -1;
    for (int i = 1; i <= 40 && nd == 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        nd++;
        dc = i;
      end
      if (i == 5) begin
        a     = 32'h40000000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("start while busy done cycle", dc, 26);
    chk("start while busy z", {z, status}, {32'h40100000, 8'h00});

    // Back-to-back: start driven in the done cycle itself.
    issue(32'h3F800001, RUP);
    wait_done(60, cyc, bok);
    chk("back-to-back latency", cyc, 26);
    chk("back-to-back result", {z, status}, {32'h3F800003, 8'h20});
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("no extra done", nd, 0);

    // enable low for 5 cycles in the middle of MUL.
    issue(32'h3F800001, RNE);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_done(60, cyc, bok);
    chk("enable stall latency", cyc + 15, 31);
    chk("enable stall result", {z, status}, {32'h3F800002, 8'h20});

    // Asynchronous reset in the middle of MUL.
    issue(32'h40000000, RNE);
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("async reset clears", {z, status, busy, done}, 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("no done after abort", nd, 0);
    run_op("after reset", 32'h3FC00000, RNE, 32'h40100000, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
